// File: rtl/fp16_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_seq_adder
//  Purpose  : Multi-cycle IEEE half-precision adder, RNE rounding, FTZ/DAZ.
//  Revision : 1.0  initial release
// ============================================================================
module fp16_seq_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        add,
    input  logic [15:0] number1,
    input  logic [15:0] number2,
    output logic [15:0] result,
    output logic        ready
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        ADDSUB = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [1:0] c_SPEC_NONE = 2'd0;
    localparam logic [1:0] c_SPEC_NAN  = 2'd1;
    localparam logic [1:0] c_SPEC_INF  = 2'd2;

    state_t r_state, w_state_next;

    logic              r_sign_a, r_sign_b;
    logic [4:0]        r_exp_a, r_exp_b;
    logic [10:0]       r_sig_a, r_sig_b;
    logic [1:0]        r_spec;
    logic              r_spec_sign;
    logic              r_sign, r_sub;
    logic [4:0]        r_exp;
    logic [13:0]       r_mant_a, r_mant_b;
    logic [14:0]       r_sum;
    logic [13:0]       r_norm;
    logic signed [6:0] r_nexp;
    logic              r_zero;
    logic [15:0]       r_result;
    logic              r_ready;

    // DONE also accepts a start so back-to-back requests run every 5 cycles
    logic w_start;
    assign w_start = ((r_state == IDLE) || (r_state == DONE)) && add;

    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    assign w_a_inf = (&number1[14:10]) && (number1[9:0] == 10'd0);
    assign w_b_inf = (&number2[14:10]) && (number2[9:0] == 10'd0);
    assign w_a_nan = (&number1[14:10]) && (number1[9:0] != 10'd0);
    assign w_b_nan = (&number2[14:10]) && (number2[9:0] != 10'd0);

    // Alignment: larger magnitude becomes A, B shifted into {sig, g, r, s}
    logic        w_a_ge;
    logic [4:0]  w_big_exp, w_sml_exp, w_diff;
    logic [10:0] w_big_sig, w_sml_sig;
    logic [13:0] w_ext, w_mask, w_aligned;
    assign w_a_ge    = {r_exp_a, r_sig_a} >= {r_exp_b, r_sig_b};
    assign w_big_exp = w_a_ge ? r_exp_a : r_exp_b;
    assign w_sml_exp = w_a_ge ? r_exp_b : r_exp_a;
    assign w_big_sig = w_a_ge ? r_sig_a : r_sig_b;
    assign w_sml_sig = w_a_ge ? r_sig_b : r_sig_a;
    assign w_diff    = w_big_exp - w_sml_exp;
    assign w_ext     = {w_sml_sig, 3'b000};

    always_comb begin
        w_mask    = ~({14{1'b1}} << w_diff);
        w_aligned = 14'd0;
        if (w_diff >= 5'd14) begin
            w_aligned = {13'd0, |w_sml_sig};
        end else begin
            w_aligned    = w_ext >> w_diff;
            w_aligned[0] = w_aligned[0] | (|(w_ext & w_mask));
        end
    end

    logic [14:0] w_sum;
    assign w_sum = r_sub ? ({1'b0, r_mant_a} - {1'b0, r_mant_b})
                         : ({1'b0, r_mant_a} + {1'b0, r_mant_b});

    logic [3:0]        w_lzc;
    logic [13:0]       w_norm;
    logic signed [6:0] w_nexp;
    always_comb begin
        w_lzc = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (r_sum[i]) w_lzc = 4'(13 - i);
        end
        if (r_sum[14]) begin
            w_norm = {r_sum[14:2], r_sum[1] | r_sum[0]};
            w_nexp = $signed({2'b00, r_exp}) + 7'sd1;
        end else begin
            w_norm = r_sum[13:0] << w_lzc;
            w_nexp = $signed({2'b00, r_exp}) - $signed({3'b000, w_lzc});
        end
    end

    logic              w_up;
    logic [11:0]       w_rmant;
    logic signed [6:0] w_rexp;
    logic [9:0]        w_frac;
    logic [15:0]       w_final;
    assign w_up    = r_norm[2] & (r_norm[3] | r_norm[1] | r_norm[0]);
    assign w_rmant = {1'b0, r_norm[13:3]} + {11'd0, w_up};
    assign w_rexp  = w_rmant[11] ? (r_nexp + 7'sd1) : r_nexp;
    assign w_frac  = w_rmant[11] ? w_rmant[10:1] : w_rmant[9:0];

    always_comb begin
        w_final = {r_sign, w_rexp[4:0], w_frac};
        if (r_spec == c_SPEC_NAN)       w_final = 16'h7E00;
        else if (r_spec == c_SPEC_INF)  w_final = {r_spec_sign, 5'h1F, 10'd0};
        else if (r_zero)                w_final = {r_sign & ~r_sub, 15'd0};
        else if (w_rexp >= 7'sd31)      w_final = {r_sign, 5'h1F, 10'd0};
        else if (w_rexp <= 7'sd0)       w_final = {r_sign, 15'd0};
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (add) w_state_next = ALIGN;
            ALIGN:   w_state_next = ADDSUB;
            ADDSUB:  w_state_next = NORM;
            NORM:    w_state_next = ROUND;
            ROUND:   w_state_next = DONE;
            DONE:    w_state_next = add ? ALIGN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_a <= 1'b0;  r_sign_b <= 1'b0;
            r_exp_a  <= 5'd0;  r_exp_b  <= 5'd0;
            r_sig_a  <= 11'd0; r_sig_b  <= 11'd0;
            r_spec   <= c_SPEC_NONE;
            r_spec_sign <= 1'b0;
            r_sign   <= 1'b0;  r_sub    <= 1'b0;
            r_exp    <= 5'd0;
            r_mant_a <= 14'd0; r_mant_b <= 14'd0;
            r_sum    <= 15'd0;
            r_norm   <= 14'd0;
            r_nexp   <= 7'sd0;
            r_zero   <= 1'b0;
            r_result <= 16'h0000;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_start) begin
                r_sign_a <= number1[15];
                r_sign_b <= number2[15];
                r_exp_a  <= number1[14:10];
                r_exp_b  <= number2[14:10];
                r_sig_a  <= (number1[14:10] == 5'd0) ? 11'd0 : {1'b1, number1[9:0]};
                r_sig_b  <= (number2[14:10] == 5'd0) ? 11'd0 : {1'b1, number2[9:0]};
                if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (number1[15] != number2[15])))
                    r_spec <= c_SPEC_NAN;
                else if (w_a_inf || w_b_inf)
                    r_spec <= c_SPEC_INF;
                else
                    r_spec <= c_SPEC_NONE;
                r_spec_sign <= w_a_inf ? number1[15] : number2[15];
            end
            if (r_state == ALIGN) begin
                r_sign   <= w_a_ge ? r_sign_a : r_sign_b;
                r_sub    <= r_sign_a != r_sign_b;
                r_exp    <= w_big_exp;
                r_mant_a <= {w_big_sig, 3'b000};
                r_mant_b <= w_aligned;
            end
            if (r_state == ADDSUB) r_sum <= w_sum;
            if (r_state == NORM) begin
                r_norm <= w_norm;
                r_nexp <= w_nexp;
                r_zero <= (r_sum == 15'd0);
            end
            if (r_state == ROUND) begin
                r_result <= w_final;
                r_ready  <= 1'b1;
            end
        end
    end

    assign result = r_result;
    assign ready  = r_ready;

endmodule
`default_nettype wire
